ghostbus_fanout: RTL and testbench

//  Parametrised ghostbus interposer: splits one host bus into NCH child buses, each owning a
//  2**CAW-word window. Registers decode and read return, so deep hierarchies close timing.

---
 rtl/ghostbus_fanout.sv | 135 +++++++++++++
 tb/tb_ghostbus_fanout.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/ghostbus_fanout.sv
// rtl/ghostbus_fanout.sv - ghostbus interposer: one host bus fanned out to NCH child windows.
// Optional error reporting and DEADBEEF read-back of unmapped reads: define GHOSTBUS_FANOUT_ERR_EN.
module ghostbus_fanout #(
  parameter int AW     = 24,
  parameter int DW     = 32,
  parameter int NCH    = 4,
  parameter int CAW    = 20,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [AW-1:0]       h_addr,
  input  logic [DW-1:0]       h_wdata,
  input  logic                h_we,
  input  logic                h_re,
  output logic [DW-1:0]       h_rdata,
  output logic                h_rvalid,
  output logic [NCH*CAW-1:0]  c_addr,
  output logic [NCH*DW-1:0]   c_wdata,
  output logic [NCH-1:0]      c_we,
  output logic [NCH-1:0]      c_re,
  input  logic [NCH*DW-1:0]   c_rdata,
  output logic                err_flag,
  output logic [7:0]          err_count
);

  localparam int SWR   = $clog2(NCH);
  localparam int SW    = (SWR == 0) ? 1 : SWR;
  localparam int DEPTH = RD_LAT + 1;
  localparam logic [SW:0] NCH_W = (SW + 1)'(NCH);
`ifdef GHOSTBUS_FANOUT_ERR_EN
  localparam logic [DW-1:0] UNM_DATA = DW'(32'hDEADBEEF);
`else
  localparam logic [DW-1:0] UNM_DATA = '0;
`endif

  typedef struct packed {
    logic          valid;
    logic [SW-1:0] sel;
    logic          unm;
  } tag_t;

  logic [SW-1:0] sel;
  logic          hi_bits;
  logic          unmapped;
  logic          do_wr;
  logic          do_rd_tag;
  logic          do_rd_child;
  tag_t          tag [DEPTH];
  tag_t          ret_tag;
  logic [DW-1:0] ret_data;

  generate
    if (SWR == 0) begin : g_sel_one
      assign sel = '0;
    end else begin : g_sel_many
      assign sel = h_addr[CAW +: SWR];
    end
    if (CAW + SWR < AW) begin : g_hi
      assign hi_bits = |h_addr[AW-1:CAW+SWR];
    end else begin : g_no_hi
      assign hi_bits = 1'b0;
    end
  endgenerate

  assign unmapped    = hi_bits || ({1'b0, sel} >= NCH_W);
  // A write wins a we/re collision; the read never enters the tag pipeline.
  assign do_wr       = h_we & ~unmapped;
  assign do_rd_tag   = h_re & ~h_we;
  assign do_rd_child = do_rd_tag & ~unmapped;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_we    <= '0;
      c_re    <= '0;
      c_addr  <= '0;
      c_wdata <= '0;
    end else begin
      c_we <= '0;
      c_re <= '0;
      if (do_wr || do_rd_child) begin
        c_addr[int'(sel)*CAW +: CAW] <= h_addr[CAW-1:0];
        c_wdata[int'(sel)*DW +: DW]  <= h_wdata;
      end
      if (do_wr)       c_we[sel] <= 1'b1;
      if (do_rd_child) c_re[sel] <= 1'b1;
    end
  end

  // Tag stage k is visible k+1 cycles after the host strobe; the last stage lines up with child data.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) tag[i] <= '0;
    end else begin
      tag[0] <= '{valid: do_rd_tag, sel: sel, unm: unmapped};
      for (int i = 1; i < DEPTH; i++) tag[i] <= tag[i-1];
    end
  end

  assign ret_tag = tag[RD_LAT];

  always_comb begin
    ret_data = UNM_DATA;
    if (!ret_tag.unm) ret_data = c_rdata[int'(ret_tag.sel)*DW +: DW];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      h_rvalid <= 1'b0;
      h_rdata  <= '0;
    end else begin
      h_rvalid <= ret_tag.valid;
      if (ret_tag.valid) h_rdata <= ret_data;
    end
  end

`ifdef GHOSTBUS_FANOUT_ERR_EN
  logic err_ev;
  assign err_ev = (h_we | h_re) & (unmapped | (h_we & h_re));

  always_ff @(posedge clk) begin
    if (rst) begin
      err_flag  <= 1'b0;
      err_count <= '0;
    end else if (err_ev) begin
      err_flag <= 1'b1;
      if (err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
  end
`else
  assign err_flag  = 1'b0;
  assign err_count = '0;
`endif

endmodule

// File: tb/tb_ghostbus_fanout.sv
// tb/tb_ghostbus_fanout.sv - randomized self-checking bench for ghostbus_fanout against a queue-based model.
module tb_ghostbus_fanout;

  localparam int AW = 24, DW = 32, NCH = 4, CAW = 20, RD_LAT = 2;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [AW-1:0]       h_addr = '0;
  logic [DW-1:0]       h_wdata = '0;
  logic                h_we = 1'b0;
  logic                h_re = 1'b0;
  logic [DW-1:0]       h_rdata;
  logic                h_rvalid;
  logic [NCH*CAW-1:0]  c_addr;
  logic [NCH*DW-1:0]   c_wdata;
  logic [NCH-1:0]      c_we;
  logic [NCH-1:0]      c_re;
  logic [NCH*DW-1:0]   c_rdata = '0;
  logic                err_flag;
  logic [7:0]          err_count;

  ghostbus_fanout #(.AW(AW), .DW(DW), .NCH(NCH), .CAW(CAW), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rst(rst), .h_addr(h_addr), .h_wdata(h_wdata), .h_we(h_we), .h_re(h_re),
    .h_rdata(h_rdata), .h_rvalid(h_rvalid), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_we(c_we), .c_re(c_re), .c_rdata(c_rdata), .err_flag(err_flag), .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rd_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          cyc = 0;
  bit          chk_en = 0;
  rd_t         rq[$];
  logic [31:0] last_rdata;
  logic [3:0]  m_we, m_re;
  logic [19:0] m_addr [NCH];
  logic [31:0] m_wdata [NCH];
  bit          m_ef;
  int          m_ec;
  logic [31:0] sched [NCH][8];
  bit          schv [NCH][8];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", tag, cyc, got, exp);
    end
  endtask

  function automatic logic [31:0] cdata(input int k, input logic [19:0] a);
    return {4'(k), 8'hC3, a};
  endfunction

  // One bus cycle: check outputs for this cycle, play the children, then drive the host strobe.
  task automatic step(input logic we, input logic re, input logic [23:0] addr,
                      input logic [31:0] wd, input logic r);
    bit          exp_v;
    bit          mapped;
    int          ch;
    logic [19:0] off;
    @(negedge clk);
    cyc++;
    if (chk_en) begin
      check_eq("c_we", 64'(c_we), 64'(m_we));
      check_eq("c_re", 64'(c_re), 64'(m_re));
      for (int k = 0; k < NCH; k++) begin
        check_eq("c_addr", 64'(c_addr[k*CAW +: CAW]), 64'(m_addr[k]));
        check_eq("c_wdata", 64'(c_wdata[k*DW +: DW]), 64'(m_wdata[k]));
      end
      exp_v = 0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        exp_v = 1;
        last_rdata = rq[0].data;
        void'(rq.pop_front());
      end
      check_eq("h_rvalid", 64'(h_rvalid), 64'(exp_v));
      check_eq("h_rdata", 64'(h_rdata), 64'(last_rdata));
      check_eq("err_flag", 64'(err_flag), 64'(m_ef));
      check_eq("err_count", 64'(err_count), 64'(m_ec));
    end
    for (int k = 0; k < NCH; k++) begin
      if (c_re[k] === 1'b1) begin
        sched[k][(cyc + RD_LAT) % 8] = cdata(k, c_addr[k*CAW +: CAW]);
        schv[k][(cyc + RD_LAT) % 8] = 1;
      end
      if (schv[k][cyc % 8]) begin
        c_rdata[k*DW +: DW] = sched[k][cyc % 8];
        schv[k][cyc % 8] = 0;
      end else begin
        c_rdata[k*DW +: DW] = $urandom;
      end
    end
    h_we = we; h_re = re; h_addr = addr; h_wdata = wd; rst = r;
    m_we = '0; m_re = '0;
    if (r) begin
      for (int k = 0; k < NCH; k++) begin m_addr[k] = '0; m_wdata[k] = '0; end
      rq.delete();
      last_rdata = '0;
      m_ef = 0;
      m_ec = 0;
      chk_en = 1;
    end else begin
      mapped = (addr[23:22] == 2'b00);
      ch = int'(addr[21:20]);
      off = addr[19:0];
`ifdef GHOSTBUS_FANOUT_ERR_EN
      if ((we || re) && (!mapped || (we && re))) begin
        m_ef = 1;
        if (m_ec < 255) m_ec++;
      end
`endif
      if (mapped && (we || re)) begin
        m_addr[ch] = off;
        m_wdata[ch] = wd;
        if (we) m_we[ch] = 1'b1;
        else m_re[ch] = 1'b1;
      end
      if (re && !we) begin
`ifdef GHOSTBUS_FANOUT_ERR_EN
        rq.push_back('{cyc + RD_LAT + 2, mapped ? cdata(ch, off) : 32'hDEADBEEF});
`else
        rq.push_back('{cyc + RD_LAT + 2, mapped ? cdata(ch, off) : 32'h0});
`endif
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
  endtask

  initial begin
    int          kind;
    logic [23:0] a;
    step(1'b0, 1'b0, 24'h0, 32'h0, 1'b1);
    step(1'b0, 1'b0, 24'h0, 32'h0, 1'b1);
    idle(2);
    step(1'b1, 1'b0, 24'h200010, 32'hA5A5_0001, 1'b0);
    step(1'b0, 1'b1, 24'h100004, 32'h0, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 24'h000020, 32'h1, 1'b0);
    step(1'b0, 1'b1, 24'h300030, 32'h2, 1'b0);
    step(1'b0, 1'b1, 24'h100040, 32'h3, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 24'h400000, 32'h0, 1'b0);
    idle(6);
    step(1'b1, 1'b1, 24'h100008, 32'h77, 1'b0);
    idle(6);
    step(1'b0, 1'b1, 24'h200008, 32'h0, 1'b0);
    step(1'b0, 1'b0, 24'h0, 32'h0, 1'b0);
    step(1'b0, 1'b1, 24'h100000, 32'h0, 1'b1);
    idle(6);
    for (int i = 0; i < 300; i++) step(1'b1, 1'b0, 24'h800000 | 24'(i), 32'(i), 1'b0);
    idle(3);
    for (int i = 0; i < 2000; i++) begin
      kind = $urandom % 8;
      if ($urandom % 100 < 85) a = {2'b00, 2'($urandom), 20'($urandom)};
      else a = {2'($urandom_range(1, 3)), 22'($urandom)};
      step(kind == 3 || kind == 4 || kind == 5, kind <= 2 || kind == 5, a, $urandom,
           ($urandom % 150) == 0);
    end
    idle(8);
    check_eq("drained", 64'(rq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
